// File: rtl/lf_ssp_tx_pkg.sv
// Shared definitions for the LF SSP sample transmitter: word width, FSM states
// and default divider/FIFO sizing.
package lf_ssp_tx_pkg;

  localparam int unsigned SSP_WORD_W     = 8;
  localparam int unsigned DEF_CLK_DIV    = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef logic [SSP_WORD_W-1:0] ssp_word_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ssp_state_e;

endpackage

// File: rtl/lf_sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers, full/empty flags, synchronous
// flush and simultaneous push/pop (a push while full is taken if a pop coincides).
module lf_sample_fifo
  import lf_ssp_tx_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      push,
  input  logic      pop,
  input  ssp_word_t wdata,
  output ssp_word_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  ssp_word_t   mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rdata = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lf_ssp_tx.sv
// LF sample transmitter: buffers 8-bit samples and streams them MSB-first on SSP.
// Optional drop counter port drop_cnt is built when LF_SSP_TX_DROP_CNT_EN is defined.
module lf_ssp_tx
  import lf_ssp_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       pck0,
  input  logic       nreset,
  input  logic       enable,
  input  logic [7:0] din,
  input  logic       din_stb,
  output logic       overflow,
  output logic       ssp_clk,
  output logic       ssp_frame,
`ifdef LF_SSP_TX_DROP_CNT_EN
  output logic       ssp_din,
  output logic [7:0] drop_cnt
`else
  output logic       ssp_din
`endif
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};

  ssp_state_e    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          ssp_clk_q, ssp_clk_d;
  logic          ssp_frame_q, ssp_frame_d;
  logic          ssp_din_q, ssp_din_d;
  logic          overflow_q, overflow_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  ssp_word_t     shift_q, shift_d;
`ifdef LF_SSP_TX_DROP_CNT_EN
  logic [7:0]    drop_cnt_q, drop_cnt_d;
`endif

  logic      terminal;
  logic      rise_tick;
  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic      drop;
  ssp_word_t fifo_rdata;

  assign terminal  = (div_q == DIV_LAST);
  assign rise_tick = enable && terminal && !ssp_clk_q;
  assign fifo_push = enable && din_stb;

  lf_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pck0),
    .rst_n (nreset),
    .clr   (!enable),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    ssp_clk_d   = ssp_clk_q;
    ssp_frame_d = ssp_frame_q;
    ssp_din_d   = ssp_din_q;
    overflow_d  = overflow_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    drop        = 1'b0;
`ifdef LF_SSP_TX_DROP_CNT_EN
    drop_cnt_d  = drop_cnt_q;
`endif

    if (!enable) begin
      state_d     = ST_IDLE;
      div_d       = '0;
      ssp_clk_d   = 1'b0;
      ssp_frame_d = 1'b0;
      ssp_din_d   = 1'b0;
      overflow_d  = 1'b0;
      bit_cnt_d   = '0;
      shift_d     = '0;
`ifdef LF_SSP_TX_DROP_CNT_EN
      drop_cnt_d  = '0;
`endif
    end else begin
      if (terminal) begin
        div_d     = '0;
        ssp_clk_d = !ssp_clk_q;
      end else begin
        div_d = div_q + DIV_ONE;
      end

      if (rise_tick) begin
        // A word boundary is either IDLE or the bit-0 period of SHIFT; both
        // reload from the FIFO when it has data, giving gapless back-to-back words.
        if (state_q == ST_SHIFT && bit_cnt_q != 3'd0) begin
          shift_d     = {shift_q[SSP_WORD_W-2:0], 1'b0};
          ssp_din_d   = shift_q[SSP_WORD_W-2];
          ssp_frame_d = 1'b0;
          bit_cnt_d   = bit_cnt_q - 3'd1;
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_d     = fifo_rdata;
          ssp_din_d   = fifo_rdata[SSP_WORD_W-1];
          ssp_frame_d = 1'b1;
          bit_cnt_d   = 3'd7;
          state_d     = ST_SHIFT;
        end else begin
          ssp_din_d   = 1'b0;
          ssp_frame_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      drop = din_stb && fifo_full && !fifo_pop;
      if (drop) begin
        overflow_d = 1'b1;
`ifdef LF_SSP_TX_DROP_CNT_EN
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
      end
    end
  end

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      ssp_clk_q   <= 1'b0;
      ssp_frame_q <= 1'b0;
      ssp_din_q   <= 1'b0;
      overflow_q  <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
`ifdef LF_SSP_TX_DROP_CNT_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      ssp_clk_q   <= ssp_clk_d;
      ssp_frame_q <= ssp_frame_d;
      ssp_din_q   <= ssp_din_d;
      overflow_q  <= overflow_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
`ifdef LF_SSP_TX_DROP_CNT_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign ssp_clk   = ssp_clk_q;
  assign ssp_frame = ssp_frame_q;
  assign ssp_din   = ssp_din_q;
  assign overflow  = overflow_q;
`ifdef LF_SSP_TX_DROP_CNT_EN
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lf_ssp_tx.sv
// Self-checking bench for lf_ssp_tx: directed scenarios plus random strobing,
// compared every cycle against a queue-based reference model.
module tb_lf_ssp_tx;

  localparam int unsigned CD    = 4;
  localparam int unsigned DEPTH = 4;

  logic       pck0 = 1'b0;
  logic       nreset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] din = '0;
  logic       din_stb = 1'b0;
  logic       overflow, ssp_clk, ssp_frame, ssp_din;
`ifdef LF_SSP_TX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  lf_ssp_tx #(
    .CLK_DIV    (CD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .pck0      (pck0),
    .nreset    (nreset),
    .enable    (enable),
    .din       (din),
    .din_stb   (din_stb),
    .overflow  (overflow),
    .ssp_clk   (ssp_clk),
    .ssp_frame (ssp_frame),
`ifdef LF_SSP_TX_DROP_CNT_EN
    .ssp_din   (ssp_din),
    .drop_cnt  (drop_cnt)
`else
    .ssp_din   (ssp_din)
`endif
  );

  always #5 pck0 = ~pck0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bit clock from elapsed enabled cycles, FIFO as a queue.
  int unsigned m_n;
  logic [7:0]  m_q[$];
  logic [7:0]  acc[$];
  bit          m_active;
  logic [7:0]  m_word;
  int          m_idx;
  bit          m_clk, m_frame, m_din, m_ovf, m_rise;
  int unsigned m_drops;

  // Monitors on DUT outputs
  int unsigned cyc = 0;
  int unsigned frames = 0;
  int unsigned frame_run = 0;
  int unsigned last_width = 0;
  int unsigned last_start = 0;
  int unsigned last_gap = 0;
  int unsigned rx_words = 0;
  int unsigned rx_cnt = 0;
  logic [7:0]  rx = '0;
  logic [7:0]  rx_last = '0;
  logic        prev_clk = 1'b0;
  logic        prev_frame = 1'b0;

  task automatic model_clear();
    m_n = 0; m_q.delete(); acc.delete(); m_active = 0; m_word = '0; m_idx = 0;
    m_clk = 0; m_frame = 0; m_din = 0; m_ovf = 0; m_rise = 0; m_drops = 0;
    rx_cnt = 0;
  endtask

  task automatic model_edge();
    bit rise;
    if (!enable) begin
      model_clear();
      return;
    end
    rise   = (m_n % (2 * CD)) == (CD - 1);
    m_n++;
    m_clk  = ((m_n / CD) % 2) == 1;
    m_rise = rise;
    if (rise) begin
      if (m_active && m_idx > 0) begin
        m_idx--;
        m_din   = m_word[m_idx];
        m_frame = 0;
      end else if (m_q.size() > 0) begin
        m_word   = m_q.pop_front();
        m_idx    = 7;
        m_din    = m_word[7];
        m_frame  = 1;
        m_active = 1;
      end else begin
        m_active = 0;
        m_din    = 0;
        m_frame  = 0;
      end
    end
    if (din_stb) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(din);
        acc.push_back(din);
      end else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic monitor();
    if (ssp_frame && !prev_frame) begin
      last_gap   = cyc - last_start;
      last_start = cyc;
      frames++;
      frame_run  = 0;
    end
    if (ssp_frame) frame_run++;
    else if (prev_frame) last_width = frame_run;
    if (prev_clk && !ssp_clk) begin
      if (ssp_frame) begin
        rx     = {7'b0, ssp_din};
        rx_cnt = 1;
      end else if (rx_cnt > 0) begin
        rx = {rx[6:0], ssp_din};
        rx_cnt++;
      end
      if (rx_cnt == 8) begin
        rx_cnt  = 0;
        rx_last = rx;
        rx_words++;
        chk("rx_expected_word", 32'(acc.size() != 0), 32'd1);
        if (acc.size() != 0) chk("rx_word", 32'(rx), 32'(acc.pop_front()));
      end
    end
    prev_clk   = ssp_clk;
    prev_frame = ssp_frame;
  endtask

  task automatic tick();
    @(posedge pck0);
    model_edge();
    @(negedge pck0);
    cyc++;
    chk("ssp_clk", 32'(ssp_clk), 32'(m_clk));
    chk("ssp_frame", 32'(ssp_frame), 32'(m_frame));
    chk("ssp_din", 32'(ssp_din), 32'(m_din));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef LF_SSP_TX_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), m_drops);
`endif
    monitor();
  endtask

  task automatic strobe(input logic [7:0] d);
    din = d; din_stb = 1'b1;
    tick();
    din_stb = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 600 && (m_active || m_q.size() != 0); i++) tick();
    chk("drain_done", 32'(m_active) + 32'(m_q.size()), 32'd0);
  endtask

  task automatic wait_rise();
    m_rise = 0;
    for (int unsigned i = 0; i < 4 * CD && !m_rise; i++) tick();
    chk("wait_rise", 32'(m_rise), 32'd1);
  endtask

  task automatic async_reset();
    nreset = 1'b0;
    #1;
    chk("rst_clk", 32'(ssp_clk), 32'd0);
    chk("rst_frame", 32'(ssp_frame), 32'd0);
    chk("rst_din", 32'(ssp_din), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    model_clear();
    prev_clk = 1'b0; prev_frame = 1'b0;
    #1 nreset = 1'b1;
  endtask

  initial begin
    int unsigned f0, w0, p;

    #1 nreset = 1'b0;
    #2;
    chk("reset_clk", 32'(ssp_clk), 32'd0);
    chk("reset_frame", 32'(ssp_frame), 32'd0);
    chk("reset_din", 32'(ssp_din), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    model_clear();
    idle(3);
    nreset = 1'b1;
    enable = 1'b1;

    // Single sample 0xA5
    strobe(8'hA5);
    f0 = frames;
    drain();
    idle(2 * CD);
    chk("a5_frames", frames - f0, 32'd1);
    chk("a5_width", last_width, 2 * CD);
    chk("a5_rx", 32'(rx_last), 32'hA5);

    // Reset in the middle of 0xA5 (bit 4 on the line)
    strobe(8'hA5);
    for (int unsigned i = 0; i < 200 && !(m_active && m_idx == 4); i++) tick();
    chk("reach_bit4", 32'(m_active && m_idx == 4), 32'd1);
    async_reset();
    f0 = frames;
    idle(20 * CD);
    chk("post_reset_frames", frames - f0, 32'd0);

    // Back-to-back 0x3C, 0xFF
    f0 = frames;
    strobe(8'h3C);
    strobe(8'hFF);
    drain();
    idle(2 * CD);
    chk("b2b_frames", frames - f0, 32'd2);
    chk("b2b_gap", last_gap, 16 * CD);
    chk("b2b_width", last_width, 2 * CD);
    chk("b2b_rx", 32'(rx_last), 32'hFF);

    // Overflow: 6 strobes while idle, away from any rise tick
    wait_rise();
    w0 = rx_words;
    for (int unsigned k = 1; k <= 6; k++) strobe(8'(k));
    chk("ovf_set", 32'(overflow), 32'd1);
`ifdef LF_SSP_TX_DROP_CNT_EN
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    drain();
    idle(2 * CD);
    chk("ovf_words", rx_words - w0, 32'd4);
    chk("ovf_last", 32'(rx_last), 32'h04);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO plus strobe on the popping rise tick
    wait_rise();
    w0 = rx_words;
    for (int unsigned k = 0; k < DEPTH; k++) strobe(8'h10 + 8'(k));
    for (int unsigned i = 0; i < 2 * CD && (m_n % (2 * CD)) != CD - 1; i++) tick();
    chk("align_pop", (m_n % (2 * CD)), CD - 1);
    strobe(8'h5A);
    chk("simul_no_ovf", 32'(overflow), 32'd0);
    drain();
    idle(2 * CD);
    chk("simul_words", rx_words - w0, DEPTH + 1);
    chk("simul_last", 32'(rx_last), 32'h5A);

    // enable low at bit 3 of 0x81 with two more queued
    strobe(8'h81);
    strobe(8'h11);
    strobe(8'h22);
    for (int unsigned i = 0; i < 200 && !(m_active && m_word == 8'h81 && m_idx == 3); i++) tick();
    chk("reach_81_bit3", 32'(m_active && m_word == 8'h81 && m_idx == 3), 32'd1);
    enable = 1'b0;
    tick();
    chk("abort_frame", 32'(ssp_frame), 32'd0);
    chk("abort_clk", 32'(ssp_clk), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    enable = 1'b1;
    f0 = frames;
    idle(20 * CD);
    chk("abort_no_frames", frames - f0, 32'd0);

    // Random strobing with occasional enable drops
    for (int unsigned blk = 0; blk < 4; blk++) begin
      p = (blk == 0) ? 5 : (blk == 1) ? 2 : (blk == 2) ? 30 : 60;
      for (int unsigned i = 0; i < 200; i++) begin
        enable  = ($urandom_range(0, 199) != 0);
        din     = 8'($urandom);
        din_stb = ($urandom_range(0, 99) < p);
        tick();
      end
      enable = 1'b1; din_stb = 1'b0;
    end
    drain();
    idle(2 * CD);
    chk("all_words_out", acc.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
